ddr3_traffic_checker: RTL

// - Self-checking DDR3 traffic generator between board-level test logic and ddr3_memory_controller.
// - On start: writes NUM_OF_WORDS patterned words from START_ADDRESS, reads them back in order, and compares.
// - Reports pass/fail, a saturating error count, and the first failing address.
// - Generalises the free-running increment tester with handshakes, data patterns, outstanding-read tracking and a read timeout.

---
 rtl/ddr3_traffic_checker_if.sv | 23 ++
 rtl/ddr3_traffic_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ddr3_traffic_checker_if.sv
// Request/return bus between the traffic checker (master) and the DDR3 memory controller (slave).
interface ddr3_traffic_checker_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              write_enable;
  logic              read_enable;
  logic              cmd_ready;
  logic [ADDR_W-1:0] i_user_data_address;
  logic [DATA_W-1:0] i_user_data;
  logic [DATA_W-1:0] o_user_data;
  logic              o_user_data_valid;

  modport master (
    output write_enable, read_enable, i_user_data_address, i_user_data,
    input  cmd_ready, o_user_data, o_user_data_valid
  );

  modport slave (
    input  write_enable, read_enable, i_user_data_address, i_user_data,
    output cmd_ready, o_user_data, o_user_data_valid
  );
endinterface

// File: rtl/ddr3_traffic_checker.sv
// Self-checking DDR3 write-then-readback traffic generator with outstanding-read tracking and timeout.
// Optional macro TRAFFIC_CHECKER_LFSR_EN adds a 32-bit Galois LFSR data pattern for mode 3.
module ddr3_traffic_checker #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int NUM_OF_WORDS          = 256,
  parameter int START_ADDRESS         = 0,
  parameter int MAX_OUTSTANDING       = 4,
  parameter int TIMEOUT_CYCLES        = 4096,
  parameter int ERR_CNT_WIDTH         = 16,
  localparam int AW = ADDRESS_BITWIDTH + BANK_ADDRESS_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               mode,
  ddr3_traffic_checker_if.master   ctrl,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [AW-1:0]            first_error_address
);
  localparam int IW = $clog2(NUM_OF_WORDS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] BASE     = AW'(START_ADDRESS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OF_WORDS - 1);
  localparam logic [IW-1:0] NUM_IDX  = IW'(NUM_OF_WORDS);
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state, state_next;

  logic [1:0]               mode_q;
  logic [IW-1:0]            wr_idx, rd_idx, ret_idx;
  logic [OW-1:0]            outstanding;
  logic [TW-1:0]            idle_cnt;
  logic                     timeout_q, err_seen;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [AW-1:0]            first_addr;
  logic [DQ_BITWIDTH-1:0]   wr_data, exp_data;
  logic start_acc, wr_acc, rd_acc, ret_any, ret_ok, ret_orphan, mismatch, time_up;

  function automatic logic [DQ_BITWIDTH-1:0] pattern(input logic [1:0] m, input logic [IW-1:0] k);
    logic [DQ_BITWIDTH-1:0] kx;
    kx = DQ_BITWIDTH'(k);
    case (m)
      2'd1:    pattern = DQ_BITWIDTH'(1) << (32'(k) % DQ_BITWIDTH);
      2'd2:    pattern = ~kx;
      default: pattern = kx;
    endcase
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

`ifdef TRAFFIC_CHECKER_LFSR_EN
  localparam logic [31:0] SEED = 32'hACE1_0001;
  logic [31:0] gen_lfsr, chk_lfsr;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
`endif

  always_comb begin
    wr_data  = pattern(mode_q, wr_idx);
    exp_data = pattern(mode_q, ret_idx);
`ifdef TRAFFIC_CHECKER_LFSR_EN
    if (mode_q == 2'd3) begin
      wr_data  = DQ_BITWIDTH'(gen_lfsr);
      exp_data = DQ_BITWIDTH'(chk_lfsr);
    end
`endif
  end

  assign start_acc  = start && (state == IDLE || state == DONE);
  assign wr_acc     = ctrl.write_enable && ctrl.cmd_ready;
  assign rd_acc     = ctrl.read_enable && ctrl.cmd_ready;
  assign ret_any    = (state == READ) && ctrl.o_user_data_valid;
  assign ret_ok     = ret_any && (outstanding != '0);
  assign ret_orphan = ret_any && (outstanding == '0);
  assign mismatch   = ret_ok && (ctrl.o_user_data != exp_data);
  assign time_up    = (state == READ) && !ctrl.o_user_data_valid && (idle_cnt == TMO_LAST);

  assign timeout             = timeout_q;
  assign error_count         = err_cnt;
  assign first_error_address = first_addr;
  assign pass                = done && (err_cnt == '0) && !timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next               = state;
    busy                     = 1'b0;
    done                     = 1'b0;
    ctrl.write_enable        = 1'b0;
    ctrl.read_enable         = 1'b0;
    ctrl.i_user_data_address = '0;
    ctrl.i_user_data         = '0;
    case (state)
      IDLE: if (start) state_next = WRITE;
      WRITE: begin
        busy                     = 1'b1;
        ctrl.write_enable        = 1'b1;
        ctrl.i_user_data_address = BASE + AW'(wr_idx);
        ctrl.i_user_data         = wr_data;
        if (ctrl.cmd_ready && wr_idx == LAST_IDX) state_next = READ;
      end
      READ: begin
        busy                     = 1'b1;
        ctrl.read_enable         = (rd_idx != NUM_IDX) && (outstanding != MAX_OUT);
        ctrl.i_user_data_address = BASE + AW'(rd_idx);
        if ((ret_ok && ret_idx == LAST_IDX) || time_up) state_next = DONE;
      end
      default: begin
        done = 1'b1;
        if (start) state_next = WRITE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q      <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      idle_cnt    <= '0;
      timeout_q   <= 1'b0;
      err_seen    <= 1'b0;
      err_cnt     <= '0;
      first_addr  <= '0;
`ifdef TRAFFIC_CHECKER_LFSR_EN
      gen_lfsr    <= '0;
      chk_lfsr    <= '0;
`endif
    end else if (start_acc) begin
      mode_q      <= mode;
      wr_idx      <= '0;
      rd_idx      <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      idle_cnt    <= '0;
      timeout_q   <= 1'b0;
      err_seen    <= 1'b0;
      err_cnt     <= '0;
      first_addr  <= '0;
`ifdef TRAFFIC_CHECKER_LFSR_EN
      gen_lfsr    <= SEED;
      chk_lfsr    <= SEED;
`endif
    end else begin
      if (wr_acc) wr_idx <= wr_idx + 1'b1;
      if (rd_acc) rd_idx <= rd_idx + 1'b1;
      if (ret_ok) ret_idx <= ret_idx + 1'b1;
`ifdef TRAFFIC_CHECKER_LFSR_EN
      if (wr_acc) gen_lfsr <= lfsr_step(gen_lfsr);
      if (ret_ok) chk_lfsr <= lfsr_step(chk_lfsr);
`endif
      // An orphan return never decrements, so outstanding cannot underflow.
      outstanding <= outstanding + OW'(rd_acc) - OW'(ret_ok);
      if (state == READ) idle_cnt <= ctrl.o_user_data_valid ? '0 : idle_cnt + 1'b1;
      if (mismatch || ret_orphan) err_cnt <= sat_inc(err_cnt);
      if (mismatch && !err_seen) begin
        err_seen   <= 1'b1;
        first_addr <= BASE + AW'(ret_idx);
      end
      if (time_up) timeout_q <= 1'b1;
    end
  end
endmodule
